// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 start-lights sequencer.
package f1_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LIGHT_UP,
        HOLD,
        GO,
        FAULT
    } state_t;

    localparam logic [6:0] LFSR_SEED = 7'h01;
    // Taps for x^7 + x^6 + 1: feedback from the two most significant bits.
    localparam logic [6:0] LFSR_TAPS = 7'h60;

    function automatic logic [6:0] lfsr_step(input logic [6:0] v);
        return {v[5:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/f1_start_ctrl_if.sv
// Handshake bundle between the race controller (master) and the start sequencer (slave).
interface f1_start_ctrl_if #(
    parameter int WIDTH    = 8,
    parameter int N_WIDTH  = 16,
    parameter int RT_WIDTH = 16
);

    logic                trigger;
    logic [N_WIDTH-1:0]  N;
    logic                react;
    logic [WIDTH-1:0]    data_out;
    logic                busy;
    logic                rt_valid;
    logic [RT_WIDTH-1:0] rt_value;
    logic                jump_start;

    modport master (
        output trigger, N, react,
        input  data_out, busy, rt_valid, rt_value, jump_start
    );

    modport slave (
        input  trigger, N, react,
        output data_out, busy, rt_valid, rt_value, jump_start
    );

endinterface

// File: rtl/f1_lfsr.sv
// Free-running 7-bit Fibonacci LFSR supplying the random hold length; never reaches zero.
module f1_lfsr
    import f1_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [6:0] lfsr_o
);

    logic [6:0] lfsr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_step(lfsr_q);
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/f1_start_ctrl.sv
// F1 start-lights sequencer: lamp build-up, random hold, lights-out and reaction timing.
// Jump-start detection (FAULT state) is built only when F1_START_JUMP_DETECT_EN is defined.
module f1_start_ctrl
    import f1_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int N_WIDTH  = 16,
    parameter int RT_WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    f1_start_ctrl_if.slave bus
);

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic [N_WIDTH-1:0]  tick_cnt_q, tick_cnt_d;
    logic [6:0]          hold_q, hold_d;
    logic [RT_WIDTH-1:0] rt_cnt_q, rt_cnt_d;
    logic [RT_WIDTH-1:0] rt_value_q, rt_value_d;
    logic                rt_valid_q, rt_valid_d;
    logic                busy_q, busy_d;
    logic [6:0]          lfsr;
    logic                tick;

    f1_lfsr u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .lfsr_o (lfsr)
    );

    assign tick = (tick_cnt_q == '0);

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        tick_cnt_d = tick_cnt_q;
        hold_d     = hold_q;
        rt_cnt_d   = rt_cnt_q;
        rt_value_d = rt_value_q;
        rt_valid_d = 1'b0;

        if (state_q != IDLE) begin
            tick_cnt_d = tick ? bus.N : tick_cnt_q - 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.trigger) begin
                    state_d    = LIGHT_UP;
                    data_d     = '0;
                    tick_cnt_d = bus.N;
                end
            end
            LIGHT_UP: begin
`ifdef F1_START_JUMP_DETECT_EN
                if (bus.react) begin
                    state_d = FAULT;
                    data_d  = '1;
                end else
`endif
                if (tick) begin
                    data_d = {data_q[WIDTH-2:0], 1'b1};
                    if (&data_q[WIDTH-2:0]) begin
                        state_d = HOLD;
                        hold_d  = lfsr;
                    end
                end
            end
            HOLD: begin
`ifdef F1_START_JUMP_DETECT_EN
                if (bus.react) begin
                    state_d = FAULT;
                    data_d  = '1;
                end else
`endif
                if (tick) begin
                    if (hold_q == 7'd1) begin
                        state_d    = GO;
                        data_d     = '0;
                        rt_cnt_d   = '0;
                        tick_cnt_d = bus.N;
                    end else begin
                        hold_d = hold_q - 7'd1;
                    end
                end
            end
            GO: begin
                // A press on a tick edge wins; that tick is not counted.
                if (bus.react) begin
                    rt_value_d = rt_cnt_q;
                    rt_valid_d = 1'b1;
                    state_d    = IDLE;
                end else if (tick && (rt_cnt_q != '1)) begin
                    rt_cnt_d = rt_cnt_q + 1'b1;
                end
            end
`ifdef F1_START_JUMP_DETECT_EN
            FAULT: begin
                if (bus.trigger) begin
                    state_d = IDLE;
                    data_d  = '0;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                data_d  = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

`ifdef F1_START_JUMP_DETECT_EN
    logic jump_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            data_q     <= '0;
            tick_cnt_q <= '0;
            hold_q     <= '0;
            rt_cnt_q   <= '0;
            rt_value_q <= '0;
            rt_valid_q <= 1'b0;
            busy_q     <= 1'b0;
`ifdef F1_START_JUMP_DETECT_EN
            jump_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            tick_cnt_q <= tick_cnt_d;
            hold_q     <= hold_d;
            rt_cnt_q   <= rt_cnt_d;
            rt_value_q <= rt_value_d;
            rt_valid_q <= rt_valid_d;
            busy_q     <= busy_d;
`ifdef F1_START_JUMP_DETECT_EN
            jump_q     <= (state_d == FAULT);
`endif
        end
    end

    assign bus.data_out = data_q;
    assign bus.busy     = busy_q;
    assign bus.rt_valid = rt_valid_q;
    assign bus.rt_value = rt_value_q;
`ifdef F1_START_JUMP_DETECT_EN
    assign bus.jump_start = jump_q;
`else
    assign bus.jump_start = 1'b0;
`endif

endmodule
